mem3_sdp_ram: RTL and testbench

Simple dual-port synchronous RAM with one write port and one registered read port sharing a single clock. It is a small scratch/operand store in the dot-product datapath: producers write vector elements by address, and the consumer reads them back one cycle later. Read and write ports operate independently and may be active in the same cycle.

---
 rtl/mem3_sdp_ram.sv | 108 ++++++++++
 tb/tb_mem3_sdp_ram.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem3_sdp_ram.sv
// -----------------------------------------------------------------------------
// mem3_sdp_ram
//
// Simple dual-port synchronous RAM: one write port and one registered read port
// on a single clock. Used as a small scratch/operand store in the dot-product
// datapath. Producers write vector elements by address, and the consumer reads
// them back one cycle later. Both ports may be active in the same cycle.
//
// Parameters
//   DATA_WIDTH    word width in bits
//   MEM_SIZE      number of storage words
//   ADDR_WIDTH    address bus width (words at or above 2**ADDR_WIDTH are
//                 unreachable when MEM_SIZE is larger)
//
// Ports
//   clk           single clock, rising-edge active
//   rst           asynchronous active-high reset; clears data_out and all words
//   write_en      write strobe
//   write_address write word index; indices >= MEM_SIZE are discarded
//   data_in       write data
//   read_en       read strobe; data_out holds its value while low
//   read_address  read word index; indices >= MEM_SIZE read as 0
//   data_out      registered read data (read-first on same-address collision)
// -----------------------------------------------------------------------------
module mem3_sdp_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MEM_SIZE   = 64,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] data_out
);

   // Addresses are widened to 32 bits so they compare cleanly against
   // MEM_SIZE and the storage index regardless of ADDR_WIDTH.
   logic [31:0]           wr_addr_ext;
   logic [31:0]           rd_addr_ext;
   logic                  wr_in_range;
   logic                  rd_in_range;

   logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
   logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [DATA_WIDTH-1:0] data_out_d;

   assign wr_addr_ext = 32'(write_address);
   assign rd_addr_ext = 32'(read_address);
   assign wr_in_range = (wr_addr_ext < MEM_SIZE);
   assign rd_in_range = (rd_addr_ext < MEM_SIZE);

   // Write path: at most one word changes, and only for an in-range address.
   // NOTE: every always_comb output starts from a full default (here the
   // current contents) so no path leaves it unassigned and infers a latch.
   always_comb begin : write_path
      mem_d = mem_q;
      if (write_en && wr_in_range) begin
         for (int unsigned i = 0; i < MEM_SIZE; i++) begin
            if (wr_addr_ext == i) begin
               mem_d[i] = data_in;
            end
         end
      end
   end

   // Read mux works from mem_q, the contents before this edge's write, which
   // is what makes a same-address read/write return the old word.
   always_comb begin : read_mux
      rd_word = '0;
      for (int unsigned i = 0; i < MEM_SIZE; i++) begin
         if (rd_addr_ext == i) begin
            rd_word = mem_q[i];
         end
      end
   end

   always_comb begin : read_path
      data_out_d = data_out_q;
      if (read_en) begin
         data_out_d = rd_in_range ? rd_word : '0;
      end
   end

   // NOTE: the storage must be cleared asynchronously on reset, so it is built
   // from resettable flops rather than a RAM macro (macros cannot be reset).
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values and simulation matches the synthesized hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q <= '0;
         for (int unsigned i = 0; i < MEM_SIZE; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         data_out_q <= data_out_d;
         mem_q      <= mem_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_mem3_sdp_ram.sv
// -----------------------------------------------------------------------------
// tb_mem3_sdp_ram
//
// Directed self-checking bench for mem3_sdp_ram. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge. A second
// instance with MEM_SIZE=12 shares the same inputs so out-of-range addresses
// are reachable with a 4-bit address bus.
// -----------------------------------------------------------------------------
module tb_mem3_sdp_ram;

   logic       clk;
   logic       rst;
   logic       write_en;
   logic [3:0] write_address;
   logic [7:0] data_in;
   logic       read_en;
   logic [3:0] read_address;
   logic [7:0] data_out;
   logic [7:0] data_out_s;

   int checks = 0;
   int errors = 0;

   mem3_sdp_ram #(
      .DATA_WIDTH(8),
      .MEM_SIZE  (64),
      .ADDR_WIDTH(4)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .write_en     (write_en),
      .write_address(write_address),
      .data_in      (data_in),
      .read_en      (read_en),
      .read_address (read_address),
      .data_out     (data_out)
   );

   mem3_sdp_ram #(
      .DATA_WIDTH(8),
      .MEM_SIZE  (12),
      .ADDR_WIDTH(4)
   ) u_small (
      .clk          (clk),
      .rst          (rst),
      .write_en     (write_en),
      .write_address(write_address),
      .data_in      (data_in),
      .read_en      (read_en),
      .read_address (read_address),
      .data_out     (data_out_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      write_en      = 1'b1;
      write_address = a;
      data_in       = d;
      cycle();
      write_en      = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      read_en      = 1'b1;
      read_address = a;
      cycle();
      read_en      = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      write_en      = 1'b0;
      write_address = '0;
      data_in       = '0;
      read_en       = 1'b0;
      read_address  = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_data_out", data_out, 8'h00);
      rst = 1'b0;
      rd(4'd0);
      check("rd0_after_reset", data_out, 8'h00);
      rd(4'd1);
      check("rd1_after_reset", data_out, 8'h00);

      // Basic write then read
      wr(4'd0, 8'h11);
      wr(4'd1, 8'h22);
      rd(4'd0);
      check("rd0_0x11", data_out, 8'h11);
      rd(4'd1);
      check("rd1_0x22", data_out, 8'h22);

      // Overwrite, then hold with read_en low while address changes
      wr(4'd1, 8'hA5);
      rd(4'd1);
      check("rd1_0xA5", data_out, 8'hA5);
      read_address = 4'd0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check($sformatf("hold_%0d", i), data_out, 8'hA5);
      end

      // Read-during-write to the same address is read-first
      wr(4'd3, 8'h33);
      write_en      = 1'b1;
      write_address = 4'd3;
      data_in       = 8'h5A;
      read_en       = 1'b1;
      read_address  = 4'd3;
      cycle();
      write_en = 1'b0;
      read_en  = 1'b0;
      check("rdw_old_0x33", data_out, 8'h33);
      rd(4'd3);
      check("rdw_new_0x5A", data_out, 8'h5A);

      // Independent read and write to different addresses in one cycle
      write_en      = 1'b1;
      write_address = 4'd4;
      data_in       = 8'h77;
      read_en       = 1'b1;
      read_address  = 4'd1;
      cycle();
      write_en = 1'b0;
      read_en  = 1'b0;
      check("indep_rd1", data_out, 8'hA5);
      rd(4'd4);
      check("indep_rd4", data_out, 8'h77);

      // Range boundary on the 12-word instance
      wr(4'd11, 8'h4B);
      wr(4'd13, 8'hEE);
      rd(4'd11);
      check("small_rd11_last", data_out_s, 8'h4B);
      check("big_rd11", data_out, 8'h4B);
      rd(4'd13);
      check("small_rd13_oor", data_out_s, 8'h00);
      check("big_rd13", data_out, 8'hEE);
      rd(4'd12);
      check("small_rd12_oor", data_out_s, 8'h00);

      // Fill all 16 addressable words, then read them back-to-back
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 8'(8'h80 + i));
      end
      read_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         read_address = 4'(i);
         cycle();
         check($sformatf("fill_rd%0d", i), data_out, 8'(8'h80 + i));
      end
      read_en = 1'b0;

      // Asynchronous reset mid-stream with a write and a read pending
      write_en      = 1'b1;
      write_address = 4'd2;
      data_in       = 8'hFF;
      read_en       = 1'b1;
      read_address  = 4'd15;
      check("pre_reset_0x8F", data_out, 8'h8F);
      #2 rst = 1'b1;
      #1 check("async_reset_now", data_out, 8'h00);
      cycle();
      check("reset_held", data_out, 8'h00);
      rst      = 1'b0;
      write_en = 1'b0;
      rd(4'd2);
      check("rd2_after_reset", data_out, 8'h00);
      rd(4'd15);
      check("rd15_cleared", data_out, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
